// File: rtl/softex_slot_table.sv
// Tagged multi-lane softmax state table: per-slot running maximum and denominator.
// Define SOFTEX_SLOT_EVICT_EN to let an ALLOC into a full table evict the oldest entry.
module softex_slot_table #(
  parameter int N_SLOTS   = 8,
  parameter int NUM_LANES = 4,
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_ACC = 32,
  parameter int ADDR_W    = 8,
  parameter logic [WIDTH_IN-1:0] MAX_INIT = 16'hFF80
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_op_i,
  input  logic [ADDR_W-1:0]              req_addr_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic                           resp_hit_o,
  output logic                           resp_err_o,
  output logic                           resp_evict_o,
  output logic [NUM_LANES*WIDTH_IN-1:0]  resp_maximum_o,
  output logic [NUM_LANES*WIDTH_ACC-1:0] resp_denominator_o,
  input  logic                           upd_valid_i,
  input  logic                           upd_op_i,
  input  logic [ADDR_W-1:0]              upd_addr_i,
  input  logic [NUM_LANES*WIDTH_IN-1:0]  upd_maximum_i,
  input  logic [NUM_LANES*WIDTH_ACC-1:0] upd_denominator_i,
  output logic                           upd_miss_o,
  output logic [$clog2(N_SLOTS+1)-1:0]   occupancy_o
);

  localparam int MW    = NUM_LANES * WIDTH_IN;
  localparam int DW    = NUM_LANES * WIDTH_ACC;
  localparam int OCC_W = $clog2(N_SLOTS + 1);
  localparam int IDX_W = $clog2(N_SLOTS);
  localparam logic [MW-1:0] MAX_INIT_ALL = {NUM_LANES{MAX_INIT}};

  logic [N_SLOTS-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  tag_q [N_SLOTS];
  logic [ADDR_W-1:0]  tag_d [N_SLOTS];
  logic [MW-1:0]      max_q [N_SLOTS];
  logic [MW-1:0]      max_d [N_SLOTS];
  logic [DW-1:0]      den_q [N_SLOTS];
  logic [DW-1:0]      den_d [N_SLOTS];

  logic          respValid_q, respHit_q, respErr_q, updMiss_q;
  logic [MW-1:0] respMax_q;
  logic [DW-1:0] respDen_q;

  logic [N_SLOTS-1:0] updHit, validPost;
  logic               reqFire, matchFound, freeFound;
  logic [IDX_W-1:0]   matchIdx, freeIdx, allocIdx;
  logic               allocGo, newHit, newErr;
  logic [MW-1:0]      newMax;
  logic [DW-1:0]      newDen;
  logic [OCC_W-1:0]   occ;

  assign reqFire     = req_valid_i && req_ready_o;
  assign req_ready_o = !respValid_q || resp_ready_i;

  always_comb begin
    updHit = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      updHit[i] = upd_valid_i && valid_q[i] && (tag_q[i] == upd_addr_i);
    end
  end

  // The request observes the table after this cycle's FREE has taken effect.
  assign validPost = upd_op_i ? (valid_q & ~updHit) : valid_q;

  always_comb begin
    matchFound = 1'b0;
    matchIdx   = '0;
    freeFound  = 1'b0;
    freeIdx    = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (validPost[i] && (tag_q[i] == req_addr_i)) begin
        matchFound = 1'b1;
        matchIdx   = IDX_W'(i);
      end
      if (!validPost[i]) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
    end
  end

`ifdef SOFTEX_SLOT_EVICT_EN
  logic [IDX_W-1:0] age_q [N_SLOTS];
  logic [IDX_W-1:0] age_d [N_SLOTS];
  logic [IDX_W-1:0] evictIdx;
  logic             newEvict, respEvict_q;

  // Strict compare keeps the lowest index among equally old entries.
  always_comb begin
    evictIdx = '0;
    for (int i = 1; i < N_SLOTS; i++) begin
      if (age_q[i] > age_q[evictIdx]) evictIdx = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    valid_d  = validPost;
    tag_d    = tag_q;
    max_d    = max_q;
    den_d    = den_q;
    allocGo  = 1'b0;
    allocIdx = '0;
    newHit   = 1'b0;
    newErr   = 1'b0;
    newMax   = '0;
    newDen   = '0;
`ifdef SOFTEX_SLOT_EVICT_EN
    age_d    = age_q;
    newEvict = 1'b0;
`endif
    for (int i = 0; i < N_SLOTS; i++) begin
      if (updHit[i] && !upd_op_i) begin
        max_d[i] = upd_maximum_i;
        den_d[i] = upd_denominator_i;
      end
    end
    if (reqFire) begin
      if (req_op_i) begin
        if (matchFound) begin
          newHit = 1'b1;
          newMax = max_d[matchIdx];
          newDen = den_d[matchIdx];
        end
      end else begin
        if (matchFound) begin
          allocGo  = 1'b1;
          allocIdx = matchIdx;
        end else if (freeFound) begin
          allocGo  = 1'b1;
          allocIdx = freeIdx;
`ifdef SOFTEX_SLOT_EVICT_EN
        end else begin
          allocGo  = 1'b1;
          allocIdx = evictIdx;
          newEvict = 1'b1;
`endif
        end
        // Initialisation is applied after the update so a same-tag ALLOC wins.
        if (allocGo) begin
          valid_d[allocIdx] = 1'b1;
          tag_d[allocIdx]   = req_addr_i;
          max_d[allocIdx]   = MAX_INIT_ALL;
          den_d[allocIdx]   = '0;
          newHit            = 1'b1;
          newMax            = MAX_INIT_ALL;
`ifdef SOFTEX_SLOT_EVICT_EN
          if (!matchFound) begin
            for (int i = 0; i < N_SLOTS; i++) begin
              if (validPost[i] && (IDX_W'(i) != allocIdx) && (age_q[i] != IDX_W'(N_SLOTS - 1)))
                age_d[i] = age_q[i] + IDX_W'(1);
            end
          end
          age_d[allocIdx] = '0;
`endif
        end else begin
          newErr = 1'b1;
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < N_SLOTS; i++) occ = occ + OCC_W'(valid_q[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q     <= '0;
      respValid_q <= 1'b0;
      respHit_q   <= 1'b0;
      respErr_q   <= 1'b0;
      respMax_q   <= '0;
      respDen_q   <= '0;
      updMiss_q   <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      updMiss_q <= upd_valid_i && !(|updHit);
      if (reqFire) begin
        respValid_q <= 1'b1;
        respHit_q   <= newHit;
        respErr_q   <= newErr;
        respMax_q   <= newMax;
        respDen_q   <= newDen;
      end else if (resp_ready_i) begin
        respValid_q <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk_i) begin
    tag_q <= tag_d;
    max_q <= max_d;
    den_q <= den_d;
`ifdef SOFTEX_SLOT_EVICT_EN
    age_q <= age_d;
`endif
  end

`ifdef SOFTEX_SLOT_EVICT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) respEvict_q <= 1'b0;
    else if (reqFire)     respEvict_q <= newEvict;
  end
  assign resp_evict_o = respEvict_q;
`else
  assign resp_evict_o = 1'b0;
`endif

  assign resp_valid_o       = respValid_q;
  assign resp_hit_o         = respHit_q;
  assign resp_err_o         = respErr_q;
  assign resp_maximum_o     = respMax_q;
  assign resp_denominator_o = respDen_q;
  assign upd_miss_o         = updMiss_q;
  assign occupancy_o        = occ;

endmodule

// File: tb/tb_softex_slot_table.sv
// Self-checking bench for softex_slot_table: directed vector table, corner sequences
// and randomized traffic against a tag-keyed reference model.
module tb_softex_slot_table;

  localparam int N  = 8;
  localparam int MW = 64;
  localparam int DW = 128;
  localparam logic [MW-1:0] INIT = {4{16'hFF80}};

  logic          clk = 1'b0;
  logic          rst, clr;
  logic          req_valid, req_ready, req_op;
  logic [7:0]    req_addr;
  logic          resp_valid, resp_ready, resp_hit, resp_err, resp_evict;
  logic [MW-1:0] resp_max;
  logic [DW-1:0] resp_den;
  logic          upd_valid, upd_op, upd_miss;
  logic [7:0]    upd_addr;
  logic [MW-1:0] upd_max;
  logic [DW-1:0] upd_den;
  logic [3:0]    occupancy;

  int errors = 0;
  int checks = 0;

  softex_slot_table dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_hit_o(resp_hit),
    .resp_err_o(resp_err), .resp_evict_o(resp_evict),
    .resp_maximum_o(resp_max), .resp_denominator_o(resp_den),
    .upd_valid_i(upd_valid), .upd_op_i(upd_op), .upd_addr_i(upd_addr),
    .upd_maximum_i(upd_max), .upd_denominator_i(upd_den),
    .upd_miss_o(upd_miss), .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: contents keyed by tag, slot number and age kept as plain integers.
  logic [MW-1:0] mMax [int];
  logic [DW-1:0] mDen [int];
  int            mSlot [int];
  int            mAge [int];
  logic          eValid, eHit, eErr, eEvict, eMiss;
  logic [MW-1:0] eMax;
  logic [DW-1:0] eDen;

  task automatic modelReset();
    mMax.delete(); mDen.delete(); mSlot.delete(); mAge.delete();
    eValid = 0; eHit = 0; eErr = 0; eEvict = 0; eMiss = 0; eMax = '0; eDen = '0;
  endtask

  function automatic int lowestFreeSlot();
    for (int s = 0; s < N; s++) begin
      bit used;
      used = 0;
      foreach (mSlot[t]) if (mSlot[t] == s) used = 1;
      if (!used) return s;
    end
    return -1;
  endfunction

  task automatic modelStep();
    logic fire;
    int   key;
    int   slot;
    if (rst || clr) begin
      modelReset();
      return;
    end
    fire = req_valid && (!eValid || resp_ready);
    eMiss = 0;
    if (upd_valid) begin
      key = int'(upd_addr);
      if (mMax.exists(key)) begin
        if (upd_op) begin
          mMax.delete(key); mDen.delete(key); mSlot.delete(key); mAge.delete(key);
        end else begin
          mMax[key] = upd_max; mDen[key] = upd_den;
        end
      end else eMiss = 1;
    end
    if (fire) begin
      key = int'(req_addr);
      eValid = 1; eHit = 0; eErr = 0; eEvict = 0; eMax = '0; eDen = '0;
      if (req_op) begin
        if (mMax.exists(key)) begin
          eHit = 1; eMax = mMax[key]; eDen = mDen[key];
        end
      end else if (mMax.exists(key)) begin
        mMax[key] = INIT; mDen[key] = '0; mAge[key] = 0;
        eHit = 1; eMax = INIT;
      end else begin
        slot = lowestFreeSlot();
`ifdef SOFTEX_SLOT_EVICT_EN
        if (slot < 0) begin
          int victim;
          victim = -1;
          foreach (mAge[t])
            if (victim < 0 || mAge[t] > mAge[victim] ||
                (mAge[t] == mAge[victim] && mSlot[t] < mSlot[victim])) victim = t;
          slot = mSlot[victim];
          mMax.delete(victim); mDen.delete(victim); mSlot.delete(victim); mAge.delete(victim);
          eEvict = 1;
        end
`endif
        if (slot >= 0) begin
          foreach (mAge[t]) if (mAge[t] < N - 1) mAge[t] = mAge[t] + 1;
          mMax[key] = INIT; mDen[key] = '0; mSlot[key] = slot; mAge[key] = 0;
          eHit = 1; eMax = INIT;
        end else eErr = 1;
      end
    end else if (resp_ready) eValid = 0;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkModel(input string n);
    checkOutput({n, " valid"}, 128'(resp_valid), 128'(eValid));
    checkOutput({n, " hit"}, 128'(resp_hit), 128'(eHit));
    checkOutput({n, " err"}, 128'(resp_err), 128'(eErr));
    checkOutput({n, " evict"}, 128'(resp_evict), 128'(eEvict));
    checkOutput({n, " max"}, 128'(resp_max), 128'(eMax));
    checkOutput({n, " den"}, resp_den, eDen);
    checkOutput({n, " miss"}, 128'(upd_miss), 128'(eMiss));
    checkOutput({n, " occ"}, 128'(occupancy), 128'(mMax.num()));
    checkOutput({n, " ready"}, 128'(req_ready), 128'(!eValid || resp_ready));
  endtask

  task automatic driveCycle(input logic rv, input logic rop, input logic [7:0] raddr,
                            input logic uv, input logic uop, input logic [7:0] uaddr,
                            input logic [MW-1:0] umax, input logic [DW-1:0] uden, input logic rr);
    req_valid = rv; req_op = rop; req_addr = raddr;
    upd_valid = uv; upd_op = uop; upd_addr = uaddr; upd_max = umax; upd_den = uden;
    resp_ready = rr;
    modelStep();
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rr);
    driveCycle(0, 0, 8'h00, 0, 0, 8'h00, '0, '0, rr);
  endtask

  task automatic doReset();
    rst = 1;
    idle(1);
    rst = 0;
  endtask

  typedef struct {
    logic rv, rop; logic [7:0] raddr;
    logic uv, uop; logic [7:0] uaddr; logic [15:0] umax; logic [31:0] uden;
    logic expValid, expHit, expMiss; logic [15:0] expMax; logic [31:0] expDen; int expOcc;
  } vec_t;

  function automatic vec_t mk(logic rv, logic rop, logic [7:0] raddr, logic uv, logic uop,
                              logic [7:0] uaddr, logic [15:0] umax, logic [31:0] uden,
                              logic ev, logic eh, logic em, logic [15:0] emax, logic [31:0] eden,
                              int eocc);
    vec_t v;
    v.rv = rv; v.rop = rop; v.raddr = raddr; v.uv = uv; v.uop = uop; v.uaddr = uaddr;
    v.umax = umax; v.uden = uden; v.expValid = ev; v.expHit = eh; v.expMiss = em;
    v.expMax = emax; v.expDen = eden; v.expOcc = eocc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    driveCycle(v.rv, v.rop, v.raddr, v.uv, v.uop, v.uaddr, {4{v.umax}}, {4{v.uden}}, 1'b1);
  endtask

  vec_t vecs [12];

  initial begin
    rst = 1; clr = 0;
    req_valid = 0; req_op = 0; req_addr = 0; resp_ready = 1;
    upd_valid = 0; upd_op = 0; upd_addr = 0; upd_max = '0; upd_den = '0;
    modelReset();

    //                rv rop addr  uv uop addr  umax      uden          V  H  M  max      den           occ
    vecs[0]  = mk(1, 1, 8'h05, 0, 0, 8'h00, 16'h0000, 32'h00000000, 1, 0, 0, 16'h0000, 32'h00000000, 0);
    vecs[1]  = mk(1, 0, 8'h05, 0, 0, 8'h00, 16'h0000, 32'h00000000, 1, 1, 0, 16'hFF80, 32'h00000000, 1);
    vecs[2]  = mk(0, 0, 8'h00, 1, 0, 8'h05, 16'h3F80, 32'h40000000, 0, 1, 0, 16'hFF80, 32'h00000000, 1);
    vecs[3]  = mk(1, 1, 8'h05, 0, 0, 8'h00, 16'h0000, 32'h00000000, 1, 1, 0, 16'h3F80, 32'h40000000, 1);
    vecs[4]  = mk(1, 0, 8'h07, 0, 0, 8'h00, 16'h0000, 32'h00000000, 1, 1, 0, 16'hFF80, 32'h00000000, 2);
    vecs[5]  = mk(1, 1, 8'h07, 1, 0, 8'h07, 16'h1234, 32'h0000ABCD, 1, 1, 0, 16'h1234, 32'h0000ABCD, 2);
    vecs[6]  = mk(0, 0, 8'h00, 1, 1, 8'h07, 16'h0000, 32'h00000000, 0, 1, 0, 16'h1234, 32'h0000ABCD, 1);
    vecs[7]  = mk(1, 1, 8'h07, 0, 0, 8'h00, 16'h0000, 32'h00000000, 1, 0, 0, 16'h0000, 32'h00000000, 1);
    vecs[8]  = mk(0, 0, 8'h00, 1, 0, 8'h09, 16'h5555, 32'h00000001, 0, 0, 1, 16'h0000, 32'h00000000, 1);
    vecs[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 32'h00000000, 0, 0, 0, 16'h0000, 32'h00000000, 1);
    vecs[10] = mk(1, 0, 8'h05, 1, 0, 8'h05, 16'h1111, 32'h00002222, 1, 1, 0, 16'hFF80, 32'h00000000, 1);
    vecs[11] = mk(1, 1, 8'h05, 0, 0, 8'h00, 16'h0000, 32'h00000000, 1, 1, 0, 16'hFF80, 32'h00000000, 1);

    doReset();
    checkOutput("reset ready", 128'(req_ready), 128'(1));
    checkOutput("reset valid", 128'(resp_valid), 128'(0));
    checkOutput("reset occ", 128'(occupancy), 128'(0));

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d valid", i), 128'(resp_valid), 128'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d hit", i), 128'(resp_hit), 128'(vecs[i].expHit));
      checkOutput($sformatf("vec%0d err", i), 128'(resp_err), 128'(0));
      checkOutput($sformatf("vec%0d max", i), 128'(resp_max), 128'({4{vecs[i].expMax}}));
      checkOutput($sformatf("vec%0d den", i), resp_den, {4{vecs[i].expDen}});
      checkOutput($sformatf("vec%0d miss", i), 128'(upd_miss), 128'(vecs[i].expMiss));
      checkOutput($sformatf("vec%0d occ", i), 128'(occupancy), 128'(vecs[i].expOcc));
      checkOutput($sformatf("vec%0d ready", i), 128'(req_ready), 128'(1));
    end

    // Fill the table, then ALLOC into it while full.
    doReset();
    for (int i = 0; i < N; i++) begin
      driveCycle(1, 0, 8'h10 + 8'(i), 0, 0, 8'h00, '0, '0, 1);
      checkModel($sformatf("fill%0d", i));
    end
    checkOutput("full occ", 128'(occupancy), 128'(8));
    driveCycle(1, 0, 8'h20, 0, 0, 8'h00, '0, '0, 1);
    checkModel("alloc full");
    checkOutput("alloc full occ", 128'(occupancy), 128'(8));
`ifdef SOFTEX_SLOT_EVICT_EN
    checkOutput("alloc full evict", 128'(resp_evict), 128'(1));
    checkOutput("alloc full hit", 128'(resp_hit), 128'(1));
    checkOutput("alloc full err", 128'(resp_err), 128'(0));
    driveCycle(1, 1, 8'h10, 0, 0, 8'h00, '0, '0, 1);
    checkOutput("evicted load hit", 128'(resp_hit), 128'(0));
`else
    checkOutput("alloc full err", 128'(resp_err), 128'(1));
    checkOutput("alloc full hit", 128'(resp_hit), 128'(0));
    driveCycle(1, 1, 8'h10, 0, 0, 8'h00, '0, '0, 1);
    checkOutput("kept load hit", 128'(resp_hit), 128'(1));
`endif
    driveCycle(1, 0, 8'h21, 1, 1, 8'h13, '0, '0, 1);
    checkModel("free+alloc");
    checkOutput("free+alloc hit", 128'(resp_hit), 128'(1));
    checkOutput("free+alloc err", 128'(resp_err), 128'(0));
    checkOutput("free+alloc evict", 128'(resp_evict), 128'(0));
    checkOutput("free+alloc occ", 128'(occupancy), 128'(8));

    // Stall the response; updates still land but the held response does not change.
    driveCycle(1, 1, 8'h11, 0, 0, 8'h00, '0, '0, 0);
    checkModel("stall start");
    for (int k = 0; k < 3; k++) begin
      driveCycle(1, 1, 8'h12, 1, 0, 8'h11, {4{16'hAAAA}}, {4{32'h00BBBB00}}, 0);
      checkOutput($sformatf("stall%0d ready", k), 128'(req_ready), 128'(0));
      checkOutput($sformatf("stall%0d valid", k), 128'(resp_valid), 128'(1));
      checkOutput($sformatf("stall%0d max", k), 128'(resp_max), 128'(INIT));
      checkOutput($sformatf("stall%0d den", k), resp_den, 128'(0));
    end
    resp_ready = 1; req_valid = 1; req_op = 1; req_addr = 8'h11; upd_valid = 0;
    #1;
    checkOutput("release ready", 128'(req_ready), 128'(1));
    driveCycle(1, 1, 8'h11, 0, 0, 8'h00, '0, '0, 1);
    checkModel("release");
    checkOutput("release max", 128'(resp_max), 128'({4{16'hAAAA}}));

    // Reset while a response is pending.
    driveCycle(1, 1, 8'h12, 0, 0, 8'h00, '0, '0, 0);
    checkOutput("pending valid", 128'(resp_valid), 128'(1));
    doReset();
    checkOutput("mid reset valid", 128'(resp_valid), 128'(0));
    checkOutput("mid reset occ", 128'(occupancy), 128'(0));
    checkOutput("mid reset ready", 128'(req_ready), 128'(1));
    driveCycle(1, 1, 8'h12, 0, 0, 8'h00, '0, '0, 1);
    checkOutput("after reset hit", 128'(resp_hit), 128'(0));

    // Randomized traffic over a small tag pool so the table fills and drains.
    for (int c = 0; c < 400; c++) begin
      clr = ($urandom_range(0, 49) == 0);
      driveCycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 8'h30 + 8'($urandom_range(0, 11)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 8'h30 + 8'($urandom_range(0, 11)),
                 {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 3) != 0);
      clr = 0;
      checkModel($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
